// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI mode-0 target.
//   state_e          : frame-level FSM states
//   CmdReadDefault   : default read command byte
//   CmdWriteDefault  : default write command byte
//   ByteW / AddrW    : data byte and register address widths
package spi_target_pkg;

  localparam int unsigned ByteW = 8;
  localparam int unsigned AddrW = 8;

  localparam logic [ByteW-1:0] CmdReadDefault  = 8'h03;
  localparam logic [ByteW-1:0] CmdWriteDefault = 8'h02;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StRdData,
    StWrData,
    StIgnore
  } state_e;

endpackage

// File: rtl/spi_tgt_sync.sv
// N-stage synchronizer for an asynchronous input, followed by one more register that
// provides the delayed level and registered rise/fall event flags.
//   clk_i, rst_ni : system clock, async active-low reset
//   d_i           : asynchronous input pin
//   level_o       : synchronized level, aligned with rise_o/fall_o
//   rise_o/fall_o : one-cycle flags for a 0->1 / 1->0 transition of level_o
module spi_tgt_sync #(
  parameter int unsigned Stages   = 2,
  parameter logic        ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [Stages-1:0] sync_q;
  logic              prev_q;
  logic              rise_q;
  logic              fall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {Stages{ResetVal}};
      prev_q <= ResetVal;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
      prev_q <= sync_q[Stages-1];
      rise_q <= sync_q[Stages-1] & ~prev_q;
      fall_q <= ~sync_q[Stages-1] & prev_q;
    end
  end

  // prev_q holds the level whose transition the flags report, so all three outputs line up.
  assign level_o = prev_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target giving an external initiator byte access to an 8-bit register space.
// Frame: command byte, address byte, then data bytes; MSB first.
//   i_clk, i_rst_n        : system clock, async active-low reset
//   i_sclk, i_csn, i_mosi : SPI pins (asynchronous)
//   o_miso, o_miso_oe     : SPI data out and its drive enable
//   o_wr_en/addr/data     : one-cycle register write strobe
//   o_rd_en/addr, i_rd_data : one-cycle read strobe, data returned one cycle later
//   o_active              : frame in progress
//   o_cmd_err             : one-cycle pulse on an unknown command byte
module spi_target
  import spi_target_pkg::*;
#(
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [ByteW-1:0] CMD_READ    = CmdReadDefault,
  parameter logic [ByteW-1:0] CMD_WRITE   = CmdWriteDefault
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_sclk,
  input  logic             i_csn,
  input  logic             i_mosi,
  output logic             o_miso,
  output logic             o_miso_oe,
  output logic             o_wr_en,
  output logic [AddrW-1:0] o_wr_addr,
  output logic [ByteW-1:0] o_wr_data,
  output logic             o_rd_en,
  output logic [AddrW-1:0] o_rd_addr,
  input  logic [ByteW-1:0] i_rd_data,
  output logic             o_active,
  output logic             o_cmd_err
);

  logic sclk_rise, sclk_fall, sclk_lvl_unused;
  logic csn_rise, csn_fall, csn_lvl_unused;
  logic mosi_lvl, mosi_edges_unused_r, mosi_edges_unused_f;

  spi_tgt_sync #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_sclk (
    .clk_i(i_clk), .rst_ni(i_rst_n), .d_i(i_sclk),
    .level_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  // CSN resets low so a reset released mid-frame sees no falling edge; the next frame
  // starts only on a genuine CSN fall.
  spi_tgt_sync #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_csn (
    .clk_i(i_clk), .rst_ni(i_rst_n), .d_i(i_csn),
    .level_o(csn_lvl_unused), .rise_o(csn_rise), .fall_o(csn_fall)
  );

  spi_tgt_sync #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_mosi (
    .clk_i(i_clk), .rst_ni(i_rst_n), .d_i(i_mosi),
    .level_o(mosi_lvl), .rise_o(mosi_edges_unused_r), .fall_o(mosi_edges_unused_f)
  );

  state_e           state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [6:0]       rx_sr_q, rx_sr_d;
  logic [ByteW-1:0] tx_sr_q, tx_sr_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic             is_read_q, is_read_d;
  logic             rd_pend_q, rd_pend_d;
  logic             skip_fall_q, skip_fall_d;
  logic             wr_en_q, wr_en_d;
  logic [AddrW-1:0] wr_addr_q, wr_addr_d;
  logic [ByteW-1:0] wr_data_q, wr_data_d;
  logic             rd_en_q, rd_en_d;
  logic [AddrW-1:0] rd_addr_q, rd_addr_d;
  logic             cmd_err_q, cmd_err_d;
  logic [ByteW-1:0] rx_byte;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      addr_q      <= '0;
      is_read_q   <= 1'b0;
      rd_pend_q   <= 1'b0;
      skip_fall_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      addr_q      <= addr_d;
      is_read_q   <= is_read_d;
      rd_pend_q   <= rd_pend_d;
      skip_fall_q <= skip_fall_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    addr_d      = addr_q;
    is_read_d   = is_read_q;
    rd_pend_d   = rd_en_q;  // read data arrives the cycle after the strobe
    skip_fall_d = skip_fall_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    cmd_err_d   = 1'b0;
    rx_byte     = {rx_sr_q, mosi_lvl};

    if (csn_fall) begin
      state_d     = StCmd;
      bit_cnt_d   = '0;
      rx_sr_d     = '0;
      tx_sr_d     = '0;
      skip_fall_d = 1'b0;
    end else if (csn_rise) begin
      // Any partial byte is simply dropped.
      state_d   = StIdle;
      bit_cnt_d = '0;
    end else if (state_q != StIdle) begin
      if (sclk_rise) begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        rx_sr_d   = rx_byte[6:0];
        if (bit_cnt_q == 3'd7) begin
          case (state_q)
            StCmd: begin
              is_read_d = (rx_byte == CMD_READ);
              if (rx_byte == CMD_READ || rx_byte == CMD_WRITE) begin
                state_d = StAddr;
              end else begin
                state_d   = StIgnore;
                cmd_err_d = 1'b1;
              end
            end
            StAddr: begin
              if (is_read_q) begin
                state_d   = StRdData;
                rd_en_d   = 1'b1;
                rd_addr_d = rx_byte;
                addr_d    = rx_byte + 8'd1;
              end else begin
                state_d = StWrData;
                addr_d  = rx_byte;
              end
            end
            StWrData: begin
              wr_en_d   = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = rx_byte;
              addr_d    = addr_q + 8'd1;
            end
            StRdData: begin
              // Prefetch for the next byte; the final one of a frame goes unused.
              rd_en_d   = 1'b1;
              rd_addr_d = addr_q;
              addr_d    = addr_q + 8'd1;
            end
            default: ;
          endcase
        end
      end
      if (sclk_fall && state_q == StRdData) begin
        // The first fall after a load keeps the freshly loaded MSB on the line.
        if (skip_fall_q) skip_fall_d = 1'b0;
        else             tx_sr_d     = {tx_sr_q[ByteW-2:0], 1'b0};
      end
      if (rd_pend_q) begin
        tx_sr_d     = i_rd_data;
        skip_fall_d = 1'b1;
      end
    end
  end

  assign o_miso_oe = (state_q == StRdData);
  assign o_miso    = (state_q == StRdData) ? tx_sr_q[ByteW-1] : 1'b0;
  assign o_active  = (state_q != StIdle);
  assign o_wr_en   = wr_en_q;
  assign o_wr_addr = wr_addr_q;
  assign o_wr_data = wr_data_q;
  assign o_rd_en   = rd_en_q;
  assign o_rd_addr = rd_addr_q;
  assign o_cmd_err = cmd_err_q;

endmodule

// File: tb/tb_spi_target.sv
module tb_spi_target;

  localparam int H = 8;  // i_clk periods per SCLK phase

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       csn = 1'b1;
  logic       mosi = 1'b0;
  logic       miso, miso_oe, wr_en, rd_en, active, cmd_err;
  logic [7:0] wr_addr, wr_data, rd_addr;
  logic [7:0] rd_data = 8'h00;

  always #5 clk = ~clk;

  spi_target #(.SYNC_STAGES(2), .CMD_READ(8'h03), .CMD_WRITE(8'h02)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sclk(sclk), .i_csn(csn), .i_mosi(mosi),
    .o_miso(miso), .o_miso_oe(miso_oe),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
    .o_active(active), .o_cmd_err(cmd_err)
  );

  // Register model: data = addr ^ FF, one cycle after the strobe.
  always @(posedge clk) if (rd_en) rd_data <= rd_addr ^ 8'hFF;

  typedef struct packed {logic [7:0] addr; logic [7:0] data;} wr_t;

  wr_t        exp_wr[$];
  logic [7:0] exp_rd[$];
  logic [7:0] exp_miso[$];
  logic [7:0] got_miso[$];
  bit         exp_err[$];
  int         checks = 0;
  int         errors = 0;
  int         oe_cnt = 0;
  wr_t        mon_wr;
  logic [7:0] mon_b;
  logic [7:0] rx;
  int         oe0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a strobe or a received byte.
  always @(negedge clk) begin
    if (rst_n) begin
      if (miso_oe) oe_cnt++;
      if (wr_en) begin
        if (exp_wr.size() == 0) chk("wr_unexpected", {wr_addr, wr_data}, 32'hFFFF_FFFF);
        else begin
          mon_wr = exp_wr.pop_front();
          chk("wr_strobe", {wr_addr, wr_data}, mon_wr);
        end
      end
      if (rd_en) begin
        if (exp_rd.size() == 0) chk("rd_unexpected", rd_addr, 32'hFFFF_FFFF);
        else begin
          mon_b = exp_rd.pop_front();
          chk("rd_strobe", rd_addr, mon_b);
        end
      end
      if (cmd_err) begin
        if (exp_err.size() == 0) chk("cmd_err_unexpected", 1, 0);
        else begin
          void'(exp_err.pop_front());
          chk("cmd_err_pulse", cmd_err, 1);
        end
      end
    end
    if (got_miso.size() > 0) begin
      mon_b = got_miso.pop_front();
      if (exp_miso.size() == 0) chk("miso_unexpected", mon_b, 32'hFFFF_FFFF);
      else chk("miso_byte", mon_b, exp_miso.pop_front());
    end
  end

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rxb);
    rxb = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi = tx[7-i];
      repeat (H) @(negedge clk);
      rxb[7-i] = miso;  // initiator samples on the rising edge
      sclk = 1'b1;
      repeat (H) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic frame_start();
    csn = 1'b0;
    repeat (H) @(negedge clk);
    chk("active_in_frame", active, 1);
  endtask

  task automatic frame_end();
    repeat (H) @(negedge clk);
    csn = 1'b1;
    repeat (2 * H) @(negedge clk);
    chk("idle_after_frame", active, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_miso"}, miso, 0);
    chk({tag, "_oe"}, miso_oe, 0);
    chk({tag, "_strobes"}, {wr_en, rd_en, cmd_err, active}, 0);
    chk({tag, "_addrs"}, {wr_addr, wr_data, rd_addr}, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2 * H) @(negedge clk);
    check_all_zero("post_reset");

    // Write 02 10 A5 5A
    oe0 = oe_cnt;
    exp_wr.push_back({8'h10, 8'hA5});
    exp_wr.push_back({8'h11, 8'h5A});
    frame_start();
    spi_bits(8'h02, 8, rx); spi_bits(8'h10, 8, rx);
    spi_bits(8'hA5, 8, rx); spi_bits(8'h5A, 8, rx);
    frame_end();
    chk("wr_oe_low", oe_cnt - oe0, 0);

    // Read 03 20 + 2 dummy bytes
    oe0 = oe_cnt;
    exp_rd.push_back(8'h20); exp_rd.push_back(8'h21); exp_rd.push_back(8'h22);
    exp_miso.push_back(8'hDF); exp_miso.push_back(8'hDE);
    frame_start();
    spi_bits(8'h03, 8, rx); spi_bits(8'h20, 8, rx);
    spi_bits(8'h00, 8, rx); got_miso.push_back(rx);
    spi_bits(8'h00, 8, rx); got_miso.push_back(rx);
    frame_end();
    chk("rd_oe_driven", oe_cnt > oe0, 1);

    // Address wrap
    exp_wr.push_back({8'hFF, 8'h11});
    exp_wr.push_back({8'h00, 8'h22});
    frame_start();
    spi_bits(8'h02, 8, rx); spi_bits(8'hFF, 8, rx);
    spi_bits(8'h11, 8, rx); spi_bits(8'h22, 8, rx);
    frame_end();

    // Unknown command
    oe0 = oe_cnt;
    exp_err.push_back(1'b1);
    frame_start();
    spi_bits(8'h7E, 8, rx); spi_bits(8'h00, 8, rx); spi_bits(8'h00, 8, rx);
    frame_end();
    chk("bad_cmd_oe_low", oe_cnt - oe0, 0);

    // Abort mid-byte, then a clean frame
    frame_start();
    spi_bits(8'h02, 8, rx); spi_bits(8'h30, 8, rx); spi_bits(8'hA8, 5, rx);
    frame_end();
    exp_wr.push_back({8'h31, 8'h44});
    frame_start();
    spi_bits(8'h02, 8, rx); spi_bits(8'h31, 8, rx); spi_bits(8'h44, 8, rx);
    frame_end();

    // Async reset in the middle of a read data byte
    exp_rd.push_back(8'h40);
    frame_start();
    spi_bits(8'h03, 8, rx); spi_bits(8'h40, 8, rx); spi_bits(8'hFF, 4, rx);
    chk("oe_before_reset", miso_oe, 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("mid_reset");
    sclk = 1'b0;
    csn = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * H) @(negedge clk);
    chk("idle_after_reset", active, 0);

    exp_wr.push_back({8'h50, 8'h77});
    frame_start();
    spi_bits(8'h02, 8, rx); spi_bits(8'h50, 8, rx); spi_bits(8'h77, 8, rx);
    frame_end();
    exp_rd.push_back(8'h60); exp_rd.push_back(8'h61);
    exp_miso.push_back(8'h9F);
    frame_start();
    spi_bits(8'h03, 8, rx); spi_bits(8'h60, 8, rx);
    spi_bits(8'h00, 8, rx); got_miso.push_back(rx);
    frame_end();

    repeat (20) @(negedge clk);
    chk("wr_queue_drained", exp_wr.size(), 0);
    chk("rd_queue_drained", exp_rd.size(), 0);
    chk("err_queue_drained", exp_err.size(), 0);
    chk("miso_queue_drained", exp_miso.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_target.md
# spi_target

SPI mode-0 target (responder) giving an external SPI initiator byte-level read/write access to an 8-bit-addressed register space in the FPGA fabric. It is the far end of the `Top` SPI initiator: single-lane (dq0 = MOSI in, dq1 = MISO out), MSB first. Pins are oversampled on the system clock, and the block drives a one-cycle register-port strobe per byte. The MISO output enable goes to the board-level IOBUF.

## Interface
- `SYNC_STAGES`, 2: flip-flop stages on `i_sclk`, `i_csn`, `i_mosi` (≥2).
- `CMD_READ`, 8'h03: read command byte.
- `CMD_WRITE`, 8'h02: write command byte.
- `i_clk`  in  1  system clock; the only clock.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_sclk`  in  1  SPI clock from initiator, asynchronous to `i_clk`.
- `i_csn`  in  1  SPI chip select, active low, asynchronous.
- `i_mosi`  in  1  SPI data from initiator.
- `o_miso`  out  1  SPI data to initiator.
- `o_miso_oe`  out  1  MISO drive enable (IOBUF `T` = ~oe).
- `o_wr_en`  out  1  one-cycle write strobe.
- `o_wr_addr`  out  8  write address, valid with `o_wr_en`.
- `o_wr_data`  out  8  write data, valid with `o_wr_en`.
- `o_rd_en`  out  1  one-cycle read strobe.
- `o_rd_addr`  out  8  read address, valid with `o_rd_en`.
- `i_rd_data`  in  8  read data, valid exactly 1 cycle after `o_rd_en`.
- `o_active`  out  1  synchronized CSN low (frame in progress).
- `o_cmd_err`  out  1  one-cycle pulse: unknown command byte received.

## Operation
- Reset values: all outputs 0; state IDLE, bit counter 0, address 0.
- Synchronize SCLK/CSN/MOSI, then register once more for edge detect. A rise event samples MOSI (synchronized, same delay as SCLK); a fall event shifts MISO.
- Frame = CSN low. Byte 0 is the command, byte 1 the address, bytes 2..n are data. A 3-bit counter counts rise events; the 8th rise completes a byte.
- States: IDLE → CMD on CSN fall. CMD → ADDR if command = CMD_READ or CMD_WRITE. CMD → IGNORE otherwise, pulsing `o_cmd_err`. ADDR → RD_DATA or WR_DATA on completion of the address byte. RD_DATA and WR_DATA loop per byte. Any state → IDLE on CSN rise (synchronized).
- WR_DATA: on byte completion, pulse `o_wr_en` with the current address and the received byte, then address += 1.
- Reads: on completion of the address byte, and of each RD_DATA byte, pulse `o_rd_en` with the current address, then address += 1. Latch `i_rd_data` into the TX shift register on the following cycle. On the next fall event, load the latched byte and drive its MSB. Subsequent fall events shift the next bit.
- `o_miso_oe` = 1 only in RD_DATA. In all other states `o_miso` = 0.
- Address is 8-bit modulo: 8'hFF + 1 wraps to 8'h00 with no flag.
- Partial byte at CSN rise: discarded, with no strobe. Counter and shift registers are cleared at the CSN fall.
- IGNORE: clocks are consumed silently until CSN rises.

## Timing
- Requirement: SCLK period ≥ 8 `i_clk` periods, and each SCLK phase ≥ 4 `i_clk` periods. CSN setup/hold to SCLK ≥ 4 `i_clk` periods.
- Let E = the `i_clk` cycle where the rise event is flagged, which is SYNC_STAGES+1 cycles after the first `i_clk` edge sampling `i_sclk` high.
- `o_wr_en`, `o_rd_en`, and `o_cmd_err` are asserted in cycle E+1.
- The read-data latch occurs at E+2. The first MISO bit is valid by E+3, ahead of the next fall event.
- `o_miso` changes in the cycle after a fall event is flagged.
- Reset mid-frame: immediate return to IDLE with all outputs 0. The frame resumes only after a new CSN falling edge.

## Structure
- `spi_target_pkg`: state enum (IDLE, CMD, ADDR, RD_DATA, WR_DATA, IGNORE), default command constants, byte/address widths.
- Sub-module `spi_tgt_sync`: parameterized N-stage synchronizer plus rise/fall edge detector. Three instances: SCLK with edges, CSN with edges, MOSI level only.
- Top FSM, counters, and shift registers live in `spi_target`.

## Test plan
- Write: CSN low, send 02 10 A5 5A, CSN high → `o_wr_en` twice: (10, A5) then (11, 5A); `o_miso_oe` stays 0.
- Read: register model returns data = addr ^ 8'hFF; send 03 20 then 2 dummy bytes → MISO returns DF DE; `o_rd_en` addrs 20, 21, 22 (last is a prefetch).
- Wrap: write 02 FF 11 22 → writes (FF, 11), (00, 22).
- Bad command: 7E 00 00 → one `o_cmd_err` pulse, no wr/rd strobes, MISO oe 0.
- Abort: 02 30 plus 5 bits, then CSN high → no `o_wr_en`. Next frame 02 31 44 writes (31, 44) correctly.
- Async reset asserted mid-read byte → all outputs 0 immediately. A frame after release behaves normally.
